// File: rtl/imc_arbiter_pkg.sv
// Shared types and defaults for the IMC round-robin arbiter.
package imc_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int unsigned DEF_N_REQ   = 2;
    localparam int unsigned DEF_W       = 16;
    localparam int unsigned DEF_RW      = 32;
    localparam int unsigned DEF_TIMEOUT = 64;

    // Index width for a value range of n entries (at least 1 bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/imc_arbiter_if.sv
// Requester and IMC-side signals of the arbiter; slave is the arbiter's view.
interface imc_arbiter_if
    import imc_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned RW    = DEF_RW
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0][W-1:0] req_a;
    logic [N_REQ-1:0][W-1:0] req_b;
    logic [N_REQ-1:0][W-1:0] req_c;
    logic [N_REQ-1:0][W-1:0] req_d;
    logic [N_REQ-1:0]        req_accept;
    logic [N_REQ-1:0]        resp_valid;
    logic [RW-1:0]           resp_data;
    logic                    resp_err;
    logic                    imc_ready;
    logic                    imc_start;
    logic [W-1:0]            a;
    logic [W-1:0]            b;
    logic [W-1:0]            c;
    logic [W-1:0]            d;
    logic                    imc_done;
    logic [RW-1:0]           imc_result;

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_d, imc_ready, imc_done, imc_result,
        output req_accept, resp_valid, resp_data, resp_err, imc_start, a, b, c, d
    );

    modport master (
        output req_valid, req_a, req_b, req_c, req_d, imc_ready, imc_done, imc_result,
        input  req_accept, resp_valid, resp_data, resp_err, imc_start, a, b, c, d
    );
endinterface

// File: rtl/imc_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module rr_pick #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IW    = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    last_i,
    output logic             found_c_o,
    output logic [IW-1:0]    g_c_o
);
    logic [IW-1:0] idx_c;

    // Scan offsets 1..N_REQ from the last grant; the first hit wins.
    always_comb begin
        found_c_o = 1'b0;
        g_c_o     = '0;
        idx_c     = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx_c = IW'((32'(last_i) + k) % N_REQ);
            if (!found_c_o && req_i[idx_c]) begin
                found_c_o = 1'b1;
                g_c_o     = idx_c;
            end
        end
    end
endmodule

// File: rtl/imc_arbiter.sv
// Shares one IMC unit between N_REQ requesters, one job at a time, round-robin.
module imc_arbiter
    import imc_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned W       = DEF_W,
    parameter int unsigned RW      = DEF_RW,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_n,
    imc_arbiter_if.slave  bus
);
    localparam int unsigned IW = idx_w(N_REQ);
    localparam int unsigned CW = idx_w(TIMEOUT);

    state_t           state_q,  state_d;
    logic [IW-1:0]    grant_q,  grant_d;
    logic [IW-1:0]    last_q,   last_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
    logic [RW-1:0]    result_q, result_d;
    logic             err_q,    err_d;
    logic [N_REQ-1:0] accept_q, accept_d;
    logic [N_REQ-1:0] rvalid_q, rvalid_d;
    logic             start_q,  start_d;

    logic             found_c;
    logic [IW-1:0]    pick_c;

    rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req_i     (bus.req_valid),
        .last_i    (last_q),
        .found_c_o (found_c),
        .g_c_o     (pick_c)
    );

    // Next-state and next-output logic; pulses default low every cycle.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        d_d      = d_q;
        result_d = result_q;
        err_d    = err_q;
        accept_d = '0;
        rvalid_d = '0;
        start_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.imc_ready && found_c) begin
                    grant_d          = pick_c;
                    a_d              = bus.req_a[pick_c];
                    b_d              = bus.req_b[pick_c];
                    c_d              = bus.req_c[pick_c];
                    d_d              = bus.req_d[pick_c];
                    accept_d[pick_c] = 1'b1;
                    start_d          = 1'b1;
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.imc_done) begin
                    result_d          = bus.imc_result;
                    err_d             = 1'b0;
                    rvalid_d[grant_q] = 1'b1;
                    state_d           = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    result_d          = '0;
                    err_d             = 1'b1;
                    rvalid_d[grant_q] = 1'b1;
                    state_d           = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset leaves requester 0 with first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            last_q   <= IW'(N_REQ - 1);
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            d_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            accept_q <= '0;
            rvalid_q <= '0;
            start_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            d_q      <= d_d;
            result_q <= result_d;
            err_q    <= err_d;
            accept_q <= accept_d;
            rvalid_q <= rvalid_d;
            start_q  <= start_d;
        end
    end

    assign bus.req_accept = accept_q;
    assign bus.resp_valid = rvalid_q;
    assign bus.resp_data  = result_q;
    assign bus.resp_err   = err_q;
    assign bus.imc_start  = start_q;
    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.c          = c_q;
    assign bus.d          = d_q;
endmodule
